// File: rtl/spi_flash_pkg.sv
// Shared opcodes, frame sizes and FSM state encoding
// for the serial SPI NOR-flash engine.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_WREN = 8'h06;

  localparam int FRAME_BYTES = 8;
  localparam int FRAME_BITS  = FRAME_BYTES * 8;
  localparam int WREN_BITS   = 8;

  typedef enum logic [2:0] {
    IDLE,
    WREN,
    GAP,
    XFER,
    DONE
  } state_t;

  function automatic logic [63:0] xfer_frame(
    input logic [7:0]  op,
    input logic [23:0] addr,
    input logic [31:0] data
  );
    return {op, addr, data};
  endfunction

endpackage

// File: rtl/spi_flash_engine_timer.sv
// SCLK half-period divider with rise/fall strobes and
// a bit counter; cleared whenever no frame is running.
module spi_bit_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic       rise,
  output logic       fall,
  output logic [5:0] bit_idx
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [HW-1:0] hcnt;
  logic          phase;
  logic          wrap;

  assign wrap = run && (hcnt == HW'(CLK_DIV - 1));
  assign rise = wrap && !phase;
  assign fall = wrap && phase;

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      hcnt    <= '0;
      phase   <= 1'b0;
      bit_idx <= '0;
    end else begin
      hcnt <= wrap ? '0 : hcnt + 1'b1;
      if (wrap)
        phase <= !phase;
      if (fall)
        bit_idx <= bit_idx + 1'b1;
    end
  end

endmodule

// File: rtl/spi_flash_engine.sv
// Word-sized SPI NOR-flash transaction engine: WREN + program
// or a single read frame, SPI mode 0, MSB first.
module spi_flash_engine
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic        p_clk,
  input  logic        p_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [23:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        s_clk,
  output logic        s_css,
  output logic        s_mosi,
  input  logic        s_miso
);

  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  state_t        state;
  state_t        state_nxt;
  logic          wr;
  logic [23:0]   addr;
  logic [31:0]   wdata;
  logic [63:0]   tx;
  logic [31:0]   rx;
  logic [GW-1:0] gcnt;
  logic          run;
  logic          rise;
  logic          fall;
  logic [5:0]    bit_idx;
  logic [5:0]    last_idx;
  logic          last;
  logic          accept;
  logic          gap_end;
  logic          xfer_end;

  spi_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk    (p_clk),
    .reset  (p_reset),
    .run    (run),
    .rise   (rise),
    .fall   (fall),
    .bit_idx(bit_idx)
  );

  assign run      = !s_css;
  assign last_idx = (state == WREN) ? 6'(WREN_BITS - 1)
                                    : 6'(FRAME_BITS - 1);
  assign last     = fall && (bit_idx == last_idx);
  assign accept   = req_valid && req_ready;
  assign gap_end  = (state == GAP) && (gcnt == GW'(CS_GAP - 1));
  // XFER holds one extra cycle after CS rises before DONE
  assign xfer_end = (state == XFER) && s_css;
  assign s_mosi   = tx[63];

  always_ff @(posedge p_clk) begin
    if (p_reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_valid)
          state_nxt = req_write ? WREN : XFER;
      end
      WREN: begin
        if (last)
          state_nxt = GAP;
      end
      GAP: begin
        if (gap_end)
          state_nxt = XFER;
      end
      XFER: begin
        if (xfer_end)
          state_nxt = DONE;
      end
      DONE: begin
        if (req_valid)
          state_nxt = req_write ? WREN : XFER;
        else
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (1'b1)
      state == IDLE: req_ready = 1'b1;
      state == DONE: begin
        req_ready = 1'b1;
        rsp_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      wr        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      tx        <= '0;
      rx        <= '0;
      gcnt      <= '0;
      s_css     <= 1'b1;
      s_clk     <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        wr    <= req_write;
        addr  <= req_addr;
        wdata <= req_wdata;
        s_css <= 1'b0;
        tx    <= req_write
               ? {OP_WREN, 56'h0}
               : xfer_frame(OP_READ, req_addr, 32'h0);
      end else if (gap_end) begin
        s_css <= 1'b0;
        tx    <= xfer_frame(OP_PP, addr, wdata);
      end else begin
        if (fall)
          tx <= {tx[62:0], 1'b0};
        if (last)
          s_css <= 1'b1;
      end

      if (rise)
        s_clk <= 1'b1;
      else if (fall)
        s_clk <= 1'b0;

      if (rise)
        rx <= {rx[30:0], s_miso};

      gcnt <= (state == GAP) ? gcnt + 1'b1 : '0;

      if (xfer_end && !wr)
        rsp_rdata <= rx;
    end
  end

endmodule

// File: tb/tb_spi_flash_engine.sv
// Directed bench with a flash model and frame/response
// scoreboards for two engines (CLK_DIV 2 and 1).
module tb_spi_flash_engine;

  localparam int CS_GAP = 4;

  typedef struct {
    int          g;
    int          n;
    logic [63:0] bits;
  } frm_t;

  typedef struct {
    int          g;
    logic [31:0] rdata;
    int          cyc;
  } rsp_t;

  logic        p_clk = 1'b0;
  logic        p_reset = 1'b1;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [23:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        s_clk     [2];
  logic        s_css     [2];
  logic        s_mosi    [2];
  logic        s_miso    [2];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  frm_t        q_frm [$];
  rsp_t        q_rsp [$];
  logic [31:0] flash_data  [2];
  logic [31:0] model_rdata [2];
  bit          skip [2];
  logic        clk_q [2];
  logic        mosi_q [2];
  logic        css_q [2];
  int          fr_n [2];
  logic [63:0] fr_bits [2];
  int          hi_run [2];
  int          last_gap [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    spi_flash_engine #(
      .CLK_DIV(g == 0 ? 2 : 1),
      .CS_GAP (CS_GAP)
    ) u_dut (
      .p_clk    (p_clk),
      .p_reset  (p_reset),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_write(req_write[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_rdata(rsp_rdata[g]),
      .s_clk    (s_clk[g]),
      .s_css    (s_css[g]),
      .s_mosi   (s_mosi[g]),
      .s_miso   (s_miso[g])
    );
  end

  always #5 p_clk = !p_clk;

  always @(posedge p_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int g, input bit w,
                          input logic [23:0] a,
                          input logic [31:0] d, input int acc);
    int   c;
    frm_t f;
    rsp_t r;
    c   = (g == 0) ? 2 : 1;
    f.g = g;
    r.g = g;
    if (w) begin
      f.n    = 8;
      f.bits = 64'h06;
      q_frm.push_back(f);
      f.n    = 64;
      f.bits = {8'h02, a, d};
      q_frm.push_back(f);
      r.rdata = model_rdata[g];
      r.cyc   = acc + 2 + 16 * c + CS_GAP + 128 * c;
    end else begin
      f.n    = 64;
      f.bits = {8'h03, a, 32'h0};
      q_frm.push_back(f);
      model_rdata[g] = flash_data[g];
      r.rdata = model_rdata[g];
      r.cyc   = acc + 2 + 128 * c;
    end
    q_rsp.push_back(r);
  endtask

  task automatic start_req(input int g, input bit w,
                           input logic [23:0] a,
                           input logic [31:0] d, input bit track);
    int n;
    n = 0;
    @(negedge p_clk);
    while (!req_ready[g] && n < 2000) begin
      @(negedge p_clk);
      n++;
    end
    chk("ready_wait", req_ready[g], 1);
    req_valid[g] = 1'b1;
    req_write[g] = w;
    req_addr[g]  = a;
    req_wdata[g] = d;
    if (track)
      push_exp(g, w, a, d, cyc);
    @(negedge p_clk);
    req_valid[g] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q_rsp.size() != 0 || q_frm.size() != 0) && n < 3000) begin
      @(negedge p_clk);
      n++;
    end
    chk("complete_in_time",
        64'(q_rsp.size() == 0 && q_frm.size() == 0), 1);
    repeat (3) @(negedge p_clk);
  endtask

  // Flash model, SPI mode checks and frame/response scoreboards
  always @(negedge p_clk) begin
    frm_t ef;
    rsp_t er;
    for (int g = 0; g < 2; g++) begin
      if (s_css[g])
        chk("sclk_low_while_cs_high", s_clk[g], 0);
      if (!s_css[g] && s_clk[g] && !clk_q[g]) begin
        chk("mosi_stable_at_rise", s_mosi[g], mosi_q[g]);
        fr_bits[g] = {fr_bits[g][62:0], s_mosi[g]};
        fr_n[g]++;
      end
      if (s_css[g] && !css_q[g]) begin
        if (skip[g]) begin
          skip[g] = 1'b0;
        end else if (q_frm.size() == 0) begin
          chk("frame_unexpected", 1, 0);
        end else begin
          ef = q_frm.pop_front();
          chk("frame_inst", 64'(g), 64'(ef.g));
          chk("frame_nbits", 64'(fr_n[g]), 64'(ef.n));
          chk("frame_bits", fr_bits[g], ef.bits);
        end
        fr_n[g]    = 0;
        fr_bits[g] = '0;
      end
      if (s_css[g]) begin
        hi_run[g]++;
      end else begin
        if (css_q[g])
          last_gap[g] = hi_run[g];
        hi_run[g] = 0;
      end
      if (!s_css[g] && fr_n[g] >= 32 && fr_n[g] < 64)
        s_miso[g] = flash_data[g][63 - fr_n[g]];
      else
        s_miso[g] = 1'b0;
      if (rsp_valid[g]) begin
        if (q_rsp.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          er = q_rsp.pop_front();
          chk("rsp_inst", 64'(g), 64'(er.g));
          chk("rsp_rdata", rsp_rdata[g], er.rdata);
          chk("rsp_cycle", 64'(cyc), 64'(er.cyc));
        end
      end
      clk_q[g]  = s_clk[g];
      mosi_q[g] = s_mosi[g];
      css_q[g]  = s_css[g];
    end
  end

  initial begin
    int n;
    for (int g = 0; g < 2; g++) begin
      req_valid[g]   = 1'b0;
      req_write[g]   = 1'b0;
      req_addr[g]    = '0;
      req_wdata[g]   = '0;
      s_miso[g]      = 1'b0;
      flash_data[g]  = '0;
      model_rdata[g] = '0;
      skip[g]        = 1'b0;
      clk_q[g]       = 1'b0;
      mosi_q[g]      = 1'b0;
      css_q[g]       = 1'b1;
      fr_n[g]        = 0;
      fr_bits[g]     = '0;
      hi_run[g]      = 0;
      last_gap[g]    = 0;
    end

    repeat (3) @(negedge p_clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_req_ready", req_ready[g], 1);
      chk("rst_rsp_valid", rsp_valid[g], 0);
      chk("rst_rsp_rdata", rsp_rdata[g], 0);
      chk("rst_s_clk", s_clk[g], 0);
      chk("rst_s_css", s_css[g], 1);
      chk("rst_s_mosi", s_mosi[g], 0);
    end
    p_reset = 1'b0;

    // Read, C=2
    flash_data[0] = 32'hDEADBEEF;
    start_req(0, 1'b0, 24'h123456, 32'h0, 1'b1);
    wait_idle();

    // Program: WREN, 4-cycle CS gap, PP frame, rdata kept
    start_req(0, 1'b1, 24'hABCDEF, 32'h01020304, 1'b1);
    wait_idle();
    chk("wren_cs_gap", 64'(last_gap[0]), CS_GAP);
    chk("pp_keeps_rdata", rsp_rdata[0], 32'hDEADBEEF);

    // Reset at bit 20 of a read frame
    flash_data[0] = 32'h76543210;
    start_req(0, 1'b0, 24'h0F0F0F, 32'h0, 1'b0);
    n = 0;
    while (fr_n[0] < 20 && n < 2000) begin
      @(negedge p_clk);
      n++;
    end
    chk("reach_bit20", 64'(fr_n[0] >= 20), 1);
    skip[0] = 1'b1;
    p_reset = 1'b1;
    @(negedge p_clk);
    chk("abort_s_css", s_css[0], 1);
    chk("abort_s_clk", s_clk[0], 0);
    chk("abort_req_ready", req_ready[0], 1);
    chk("abort_rsp_valid", rsp_valid[0], 0);
    p_reset = 1'b0;
    model_rdata[0] = '0;
    model_rdata[1] = '0;
    flash_data[0] = 32'hCAFEF00D;
    start_req(0, 1'b0, 24'h123456, 32'h0, 1'b1);
    wait_idle();

    // Held request with changing inputs, then back-to-back in DONE
    flash_data[0] = 32'h89ABCDEF;
    @(negedge p_clk);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_addr[0]  = 24'h111111;
    push_exp(0, 1'b0, 24'h111111, 32'h0, cyc);
    n = 0;
    do begin
      @(negedge p_clk);
      n++;
      if (!rsp_valid[0])
        req_addr[0] = 24'h300000 + 24'(cyc);
    end while (!rsp_valid[0] && n < 2000);
    chk("done_seen", rsp_valid[0], 1);
    chk("done_ready", req_ready[0], 1);
    req_addr[0] = 24'h222222;
    push_exp(0, 1'b0, 24'h222222, 32'h0, cyc);
    @(negedge p_clk);
    req_valid[0] = 1'b0;
    chk("b2b_css_low", s_css[0], 0);
    chk("b2b_busy", req_ready[0], 0);
    wait_idle();

    // Read, C=1
    flash_data[1] = 32'h5A5AA5A5;
    start_req(1, 1'b0, 24'h000000, 32'h0, 1'b1);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
